dot_product_seq: RTL and testbench
==================================

# dot_product_seq

Sequencer that sits directly upstream of the MAC accumulator and drives its `En`/`Clr`/`Ain`/`Bin` inputs. It accepts a stream of operand pairs on a valid/ready handshake, with `in_last` marking the final pair, and clears the MAC before each vector. It also reads back the MAC's `Cout` and presents the finished dot product on a valid/ready result port. One `dot_product_seq` pairs with one MAC instance; both share clock and reset.

## Interface
- `DATA_WIDTH`, 8: operand width; must match the attached MAC.
- `MAX_LEN`, 16: maximum number of terms per vector (≥2). `CW = $clog2(MAX_LEN+1)`.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset, shared with the MAC.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: sequencer accepts the pair this cycle.
- `in_a`, `in_b` in DATA_WIDTH: operands.
- `in_last` in 1: qualifies the final pair of the vector.
- `mac_en` out 1: to MAC `En`.
- `mac_clr` out 1: to MAC `Clr`.
- `mac_a`, `mac_b` out DATA_WIDTH: to MAC `Ain`/`Bin`.
- `mac_cout` in 3*DATA_WIDTH: from MAC `Cout`.
- `res_valid` out 1: result valid.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 3*DATA_WIDTH: registered dot product.
- `res_count` out CW: number of terms accepted for this result.
- `res_overlen` out 1: vector was truncated at MAX_LEN.

## Operation
- FSM states: CLEAR, ACCUM, DRAIN, HOLD. Reset enters CLEAR.
- **CLEAR:** `mac_clr`=1, `in_ready`=0, beat counter := 0. Next state is ACCUM.
- **ACCUM:** `in_ready`=1.
  - On handshake (`in_valid & in_ready`), `mac_en`=1 and `mac_a`/`mac_b` = `in_a`/`in_b`, combinational pass-through. The counter increments.
  - The vector ends if `in_last`=1, or if the counter reaches MAX_LEN on this beat. On either, go to DRAIN.
  - When the vector ends on the MAX_LEN-th beat with `in_last`=0, the overlen flag is set. Subsequent pairs belong to the next vector.
- **DRAIN:** `in_ready`=0, `mac_en`=0. `mac_cout` now holds the final sum.
  - At the end of the cycle: `res_data` := `mac_cout`, `res_count` := counter, `res_overlen` := overlen flag.
  - Next state is HOLD.
- **HOLD:** `res_valid`=1 and `in_ready`=0.
  - `res_data`, `res_count` and `res_overlen` are stable until `res_ready`=1.
  - On `res_valid & res_ready`, go to CLEAR. `res_valid` drops the next cycle.
- `mac_a`/`mac_b` are 0 whenever no handshake occurs. `mac_en` and `mac_clr` are never both 1.
- Arithmetic is owned by the MAC. The sum wraps modulo 2^(3*DATA_WIDTH); this block performs no saturation.
- `in_last` with `in_valid`=0 is ignored.

## Timing
- Reset values:
  - `res_valid`=0, `res_data`=0, `res_count`=0, `res_overlen`=0.
  - `in_ready`=0, `mac_en`=0.
  - `mac_clr`=1, because the FSM sits in CLEAR.
- The first `in_ready`=1 occurs in the 2nd cycle after `rst_n` deasserts.
- Last beat accepted in cycle t → DRAIN in t+1 → `res_valid`=1 in t+2.
- Result handshake in cycle h → CLEAR in h+1 → `in_ready`=1 in h+2.
- Back-to-back vectors with `res_ready` tied high: 3 bubble cycles per vector (DRAIN, HOLD, CLEAR).
- A one-beat vector is legal: `res_count`=1.
- Asynchronous reset mid-vector or mid-HOLD:
  - All outputs return to their reset values immediately and the FSM goes to CLEAR.
  - The partial vector is discarded and produces no result.

## Configuration
- `DOT_PRODUCT_SEQ_ZERO_SKIP_EN` defined:
  - An accepted beat with `in_a`==0 or `in_b`==0 keeps `mac_en`=0 and `mac_a`/`mac_b`=0, to save MAC switching power.
  - The beat still counts toward `res_count`/MAX_LEN and still honours `in_last`.
  - `res_data` is unchanged versus the non-skip build.
- Undefined: every accepted beat asserts `mac_en`.

## Test plan
- **Basic dot product:** reset, then vector (1,2),(3,4),(5,6) with last on the third beat and `res_ready`=1 → `res_data`=44, `res_count`=3, `res_overlen`=0, `res_valid` 2 cycles after the last beat.
- **Backpressure:** vector (255,255)×2 with `res_ready`=0 for 5 cycles → `res_valid` held and `res_data`=130050 stable; `in_ready`=0 throughout; accepting restarts with `mac_clr` for 1 cycle.
- **Overlength:** MAX_LEN=4; 6 beats of (1,1) with no `in_last` → first result `res_data`=4, `res_count`=4, `res_overlen`=1. The remaining 2 beats are then accepted into a second vector, closed by a 7th beat (1,1) with `in_last`=1 → second result `res_data`=3, `res_count`=3, `res_overlen`=0.
- **Input gaps and single-beat vector:** `in_valid` toggling between beats of (2,3),(4,5) → `res_data`=26; then a single beat (7,9,last) → `res_data`=63, `res_count`=1.
- **Reset mid-vector:** reset after 2 beats of (10,10) → outputs at reset values; a new vector (1,1,last) → `res_data`=1.
- **Zero-skip build:** vector (0,5),(3,0),(2,2 last) with the macro defined → `mac_en` high only on the third beat; `res_data`=4, `res_count`=3.

Source files
------------

// File: rtl/dot_product_seq_if.sv
// Bundle of the sequencer's stream, MAC-side and result signals.
// master: upstream producer / MAC / result consumer side.
// slave:  the dot_product_seq sequencer.
interface dot_product_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 16
);
  localparam int CW = $clog2(MAX_LEN + 1);

  // operand stream
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_a;
  logic [DATA_WIDTH-1:0]   in_b;
  logic                    in_last;

  // MAC control and read-back
  logic                    mac_en;
  logic                    mac_clr;
  logic [DATA_WIDTH-1:0]   mac_a;
  logic [DATA_WIDTH-1:0]   mac_b;
  logic [3*DATA_WIDTH-1:0] mac_cout;

  // result port
  logic                    res_valid;
  logic                    res_ready;
  logic [3*DATA_WIDTH-1:0] res_data;
  logic [CW-1:0]           res_count;
  logic                    res_overlen;

  modport master (
    output in_valid, in_a, in_b, in_last,
    input  in_ready,
    input  mac_en, mac_clr, mac_a, mac_b,
    output mac_cout,
    input  res_valid, res_data, res_count, res_overlen,
    output res_ready
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last,
    output in_ready,
    output mac_en, mac_clr, mac_a, mac_b,
    input  mac_cout,
    output res_valid, res_data, res_count, res_overlen,
    input  res_ready
  );
endinterface

// File: rtl/dot_product_seq.sv
// dot_product_seq: drives an external MAC (En/Clr/Ain/Bin) from a valid/ready
// operand stream, clears it before every vector and returns the finished sum
// on a valid/ready result port.
// Optional build macro: DOT_PRODUCT_SEQ_ZERO_SKIP_EN -- beats with a zero
// operand are counted but do not enable the MAC (saves MAC switching power).
module dot_product_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 16
) (
  input logic             clk,
  input logic             rst_n,
  dot_product_seq_if.slave bus
);
  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] beat_cnt;
  logic          overlen;

  logic          fire;
  logic          take;
  logic [CW-1:0] beat_cnt_nxt;
  logic          at_cap;

  assign fire         = bus.in_valid & bus.in_ready;
  assign beat_cnt_nxt = beat_cnt + CW'(1);
  assign at_cap       = (beat_cnt_nxt == CW'(MAX_LEN));

  // MAC operand pass-through; operands are zeroed whenever no beat is forwarded.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
`ifdef DOT_PRODUCT_SEQ_ZERO_SKIP_EN
    take = fire && (bus.in_a != '0) && (bus.in_b != '0);
`else
    take = fire;
`endif
    bus.mac_en = take;
    bus.mac_a  = take ? bus.in_a : '0;
    bus.mac_b  = take ? bus.in_b : '0;
  end

  // Sequencer FSM with registered in_ready / mac_clr / res_valid and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= CLEAR;
      beat_cnt        <= '0;
      overlen         <= 1'b0;
      bus.in_ready    <= 1'b0;
      bus.mac_clr     <= 1'b1;
      bus.res_valid   <= 1'b0;
      bus.res_data    <= '0;
      bus.res_count   <= '0;
      bus.res_overlen <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
      case (state)
        CLEAR: begin
          beat_cnt     <= '0;
          overlen      <= 1'b0;
          bus.mac_clr  <= 1'b0;
          bus.in_ready <= 1'b1;
          state        <= ACCUM;
        end
        ACCUM: begin
          if (fire) begin
            beat_cnt <= beat_cnt_nxt;
            if (bus.in_last || at_cap) begin
              // a vector closed by the length cap (not by in_last) is flagged truncated
              overlen      <= ~bus.in_last;
              bus.in_ready <= 1'b0;
              state        <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // the MAC registered the last product on the previous edge; Cout is final now
          bus.res_data    <= bus.mac_cout;
          bus.res_count   <= beat_cnt;
          bus.res_overlen <= overlen;
          bus.res_valid   <= 1'b1;
          state           <= HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.mac_clr   <= 1'b1;
            state         <= CLEAR;
          end
        end
        default: begin
          bus.in_ready  <= 1'b0;
          bus.res_valid <= 1'b0;
          bus.mac_clr   <= 1'b1;
          state         <= CLEAR;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dot_product_seq.sv
// Self-checking bench for dot_product_seq. Contains a behavioural MAC as the
// attached accumulator, and a stream-level reference model that derives the
// expected results from the accepted operand pairs.
module tb_dot_product_seq;
  localparam int DW      = 8;
  localparam int MAX_LEN = 4;
  localparam int CW      = $clog2(MAX_LEN + 1);

  typedef struct {
    logic [3*DW-1:0] data;
    int              cnt;
    bit              ov;
  } res_t;

  logic clk;
  logic rst_n;
  dot_product_seq_if #(.DATA_WIDTH(DW), .MAX_LEN(MAX_LEN)) bus ();

  dot_product_seq #(.DATA_WIDTH(DW), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural MAC: Clr zeroes, En adds Ain*Bin, wraps modulo 2^(3*DW)
  logic [3*DW-1:0] mac_acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           mac_acc <= '0;
    else if (bus.mac_clr) mac_acc <= '0;
    else if (bus.mac_en)  mac_acc <= mac_acc + (3*DW)'(bus.mac_a) * (3*DW)'(bus.mac_b);
  end
  assign bus.mac_cout = mac_acc;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model and monitor state
  longint part_sum = 0;
  int     part_cnt = 0;
  res_t   exp_q[$];
  res_t   obs_q[$];
  int     en_cnt = 0;
  int     end_cyc = 0;
  int     hs_cyc = 0;
  bit     hs_valid = 0;
  bit     prev_rv = 0;
  bit     prev_ir = 0;
  logic [3*DW+CW:0] prev_res = '0;

  // Sample everything on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (!rst_n) begin
      part_sum = 0;
      part_cnt = 0;
      exp_q.delete();
      prev_rv  = 0;
      prev_ir  = 0;
      hs_valid = 0;
    end else begin
      bit   fire;
      bit   exp_en;
      res_t r;
      fire = bus.in_valid && bus.in_ready;
      if (fire) begin
`ifdef DOT_PRODUCT_SEQ_ZERO_SKIP_EN
        exp_en = (bus.in_a != 0) && (bus.in_b != 0);
`else
        exp_en = 1'b1;
`endif
        check("mac_en_beat", bus.mac_en, exp_en);
        check("mac_a_beat", bus.mac_a, exp_en ? bus.in_a : 0);
        check("mac_b_beat", bus.mac_b, exp_en ? bus.in_b : 0);
        part_sum += longint'(bus.in_a) * longint'(bus.in_b);
        part_cnt++;
        if (bus.in_last || part_cnt == MAX_LEN) begin
          r.data = (3*DW)'(part_sum);
          r.cnt  = part_cnt;
          r.ov   = !bus.in_last;
          exp_q.push_back(r);
          part_sum = 0;
          part_cnt = 0;
          end_cyc  = cyc;
        end
      end else begin
        check("mac_idle", {bus.mac_en, bus.mac_a, bus.mac_b}, 0);
      end
      if (bus.mac_en) en_cnt++;
      check("clr_en_excl", bus.mac_clr & bus.mac_en, 0);
      if (bus.res_valid && !prev_rv) check("res_latency", cyc - end_cyc, 2);
      if (bus.res_valid && prev_rv)
        check("res_stable", {bus.res_data, bus.res_count, bus.res_overlen}, prev_res);
      if (bus.in_ready && !prev_ir && hs_valid) begin
        check("restart_latency", cyc - hs_cyc, 2);
        hs_valid = 0;
      end
      if (bus.res_valid && bus.res_ready) begin
        r.data = bus.res_data;
        r.cnt  = int'(bus.res_count);
        r.ov   = bus.res_overlen;
        obs_q.push_back(r);
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("res_data", r.data, e.data);
          check("res_count", r.cnt, e.cnt);
          check("res_overlen", r.ov, e.ov);
        end
        hs_cyc   = cyc;
        hs_valid = 1;
      end
      prev_rv  = bus.res_valid;
      prev_ir  = bus.in_ready;
      prev_res = {bus.res_data, bus.res_count, bus.res_overlen};
    end
  end

  bit rr_random = 0;

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
    if (rr_random) bus.res_ready = 1'($urandom % 2);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // offer one pair and hold it until accepted (bounded)
  task automatic send(input int a, input int b, input bit last);
    bit ok;
    int n;
    bus.in_valid = 1'b1;
    bus.in_a     = DW'(a);
    bus.in_b     = DW'(b);
    bus.in_last  = last;
    ok = 0;
    n  = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = bus.in_ready;
      step();
      n++;
    end
    if (!ok) check("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_results();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    idle(3);
  endtask

  task automatic expect_res(input string tag, input int idx, input int data, input int cnt, input bit ov);
    check({tag, "_present"}, obs_q.size() > idx, 1);
    if (obs_q.size() > idx) begin
      check({tag, "_data"}, obs_q[idx].data, data);
      check({tag, "_count"}, obs_q[idx].cnt, cnt);
      check({tag, "_ov"}, obs_q[idx].ov, ov);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_res_data"}, bus.res_data, 0);
    check({tag, "_res_count"}, bus.res_count, 0);
    check({tag, "_res_overlen"}, bus.res_overlen, 0);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_mac_en"}, bus.mac_en, 0);
    check({tag, "_mac_clr"}, bus.mac_clr, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    int en0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.res_ready = 1'b1;

    // reset state and first in_ready timing
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("first_cycle_in_ready", bus.in_ready, 0);
    check("first_cycle_mac_clr", bus.mac_clr, 1);
    @(negedge clk);
    check("second_cycle_in_ready", bus.in_ready, 1);
    check("second_cycle_mac_clr", bus.mac_clr, 0);
    step();

    // basic dot product
    base = obs_q.size();
    send(1, 2, 0);
    send(3, 4, 0);
    send(5, 6, 1);
    wait_results();
    expect_res("basic", base, 44, 3, 0);

    // backpressure
    bus.res_ready = 1'b0;
    send(255, 255, 0);
    send(255, 255, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.res_valid && n < 20);
    check("bp_valid_seen", bus.res_valid, 1);
    repeat (5) begin
      check("bp_held_valid", bus.res_valid, 1);
      check("bp_held_data", bus.res_data, 130050);
      check("bp_held_count", bus.res_count, 2);
      check("bp_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    step();
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", bus.res_valid, 1);
    @(negedge clk);
    check("bp_clear_clr", bus.mac_clr, 1);
    check("bp_clear_in_ready", bus.in_ready, 0);
    check("bp_clear_valid", bus.res_valid, 0);
    @(negedge clk);
    check("bp_accum_clr", bus.mac_clr, 0);
    check("bp_accum_in_ready", bus.in_ready, 1);
    step();

    // overlength split at MAX_LEN
    base = obs_q.size();
    repeat (6) send(1, 1, 0);
    send(1, 1, 1);
    wait_results();
    expect_res("overlen_first", base, 4, 4, 1);
    expect_res("overlen_second", base + 1, 3, 3, 0);

    // input gaps, then a single-beat vector
    base = obs_q.size();
    send(2, 3, 0);
    idle(2);
    send(4, 5, 1);
    wait_results();
    send(7, 9, 1);
    wait_results();
    expect_res("gaps", base, 26, 2, 0);
    expect_res("single", base + 1, 63, 1, 0);

    // asynchronous reset in the middle of a vector
    base = obs_q.size();
    send(10, 10, 0);
    send(10, 10, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    idle(2);
    rst_n = 1'b1;
    send(1, 1, 1);
    wait_results();
    check("midreset_one_result", obs_q.size() - base, 1);
    expect_res("midreset_new", base, 1, 1, 0);

    // zero operands: skipped on the MAC only in the zero-skip build
    base = obs_q.size();
    en0  = en_cnt;
    send(0, 5, 0);
    send(3, 0, 0);
    send(2, 2, 1);
    wait_results();
    expect_res("zero", base, 4, 3, 0);
`ifdef DOT_PRODUCT_SEQ_ZERO_SKIP_EN
    check("zero_en_beats", en_cnt - en0, 1);
`else
    check("zero_en_beats", en_cnt - en0, 3);
`endif

    // randomized vectors with gaps, zero operands and result backpressure
    rr_random = 1;
    for (int v = 0; v < 30; v++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        int a;
        int b;
        a = ($urandom % 5 == 0) ? 0 : $urandom_range(0, 255);
        b = ($urandom % 5 == 0) ? 0 : $urandom_range(0, 255);
        send(a, b, (i == len - 1) && ($urandom % 4 != 0));
        idle($urandom % 3);
      end
    end
    send($urandom_range(0, 255), $urandom_range(0, 255), 1);
    rr_random     = 0;
    bus.res_ready = 1'b1;
    wait_results();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
